// File: rtl/stream_fifo_push_arbiter_pkg.sv
// Shared types for the stream FIFO push arbiter.
// State encoding plus the occupancy-width helper.
package stream_fifo_push_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_e;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_push_arbiter_if.sv
// Producer-side and FIFO-side signals of the push arbiter.
// master is the arbiter view, slave the environment view.
interface stream_fifo_push_arbiter_if
  import stream_fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16
);
  localparam int OW = occ_w(DEPTH);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_payload;
  logic [NUM_REQ-1:0]        req_last;
  logic                      fifo_push_valid;
  logic                      fifo_push_ready;
  logic [DATA_W-1:0]         fifo_push_payload;
  logic [OW-1:0]             fifo_occupancy;
  logic                      fifo_flush;
  logic                      flush_req;
  logic                      flush_ack;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  modport master (
    input  req_valid, req_payload, req_last,
    input  fifo_push_ready, fifo_occupancy,
    input  flush_req,
    output req_ready, fifo_push_valid,
    output fifo_push_payload, fifo_flush,
    output flush_ack, grant, busy
  );

  modport slave (
    output req_valid, req_payload, req_last,
    output fifo_push_ready, fifo_occupancy,
    output flush_req,
    input  req_ready, fifo_push_valid,
    input  fifo_push_payload, fifo_flush,
    input  flush_ack, grant, busy
  );

endinterface

// File: rtl/stream_fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after ptr_i, wrapping modulo N.
module stream_fifo_push_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          any_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/stream_fifo_push_arbiter.sv
// Round-robin burst-locked arbiter for the FIFO push port,
// with free-space admission and burst-safe flush sequencing.
module stream_fifo_push_arbiter
  import stream_fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_BURST  = 8,
  parameter int START_FREE = 4
) (
  input logic clk,
  input logic reset,
  stream_fifo_push_arbiter_if.master bus
);

  localparam int OW = occ_w(DEPTH);
  localparam int PW = $clog2(NUM_REQ);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [7:0]         beat_cnt_q;
  logic               flush_pend_q;

  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic [PW-1:0]      pick_idx;
  logic [OW-1:0]      free;
  logic [DATA_W-1:0]  owner_pay;
  logic               in_burst;
  logic               beat;
  logic               owner_last;
  logic               burst_end;

  stream_fifo_push_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick),
    .any_o  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  always_comb begin
    owner_pay = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i])
        owner_pay = bus.req_payload[i*DATA_W +: DATA_W];
  end

  // Occupancy never exceeds DEPTH, so this cannot wrap.
  assign free     = OW'(DEPTH) - bus.fifo_occupancy;
  assign in_burst = (state_q == BURST);

  assign bus.fifo_push_valid =
    in_burst && |(grant_q & bus.req_valid);
  assign bus.fifo_push_payload = owner_pay;
  assign bus.req_ready = in_burst ?
    (grant_q & {NUM_REQ{bus.fifo_push_ready}}) : '0;

  assign beat       = bus.fifo_push_valid && bus.fifo_push_ready;
  assign owner_last = |(grant_q & bus.req_last);
  assign burst_end  = beat &&
    (owner_last || beat_cnt_q == 8'(MAX_BURST - 1));

  assign bus.fifo_flush = (state_q == FLUSH);
  assign bus.flush_ack  = (state_q == FLUSH);
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant      = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_pend_q || bus.flush_req) begin
            state_q <= FLUSH;
          end else if (any && free >= OW'(START_FREE)) begin
            grant_q    <= pick;
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (bus.flush_req) flush_pend_q <= 1'b1;
          if (burst_end) begin
            rr_ptr_q <= (owner_q == PW'(NUM_REQ - 1)) ?
              '0 : owner_q + 1'b1;
            grant_q  <= '0;
            state_q  <= IDLE;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        FLUSH: begin
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_fifo_push_arbiter.sv
// Scoreboard bench for stream_fifo_push_arbiter: producer
// queues feed the DUT, pushes are matched per producer.
module tb_stream_fifo_push_arbiter;
  import stream_fifo_push_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_fifo_push_arbiter_if #(
    .NUM_REQ (N), .DATA_W (W), .DEPTH (D)
  ) bus ();

  stream_fifo_push_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .DEPTH      (D),
    .MAX_BURST  (8),
    .START_FREE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int flushes  = 0;
  int seq      = 0;
  logic [N-1:0] fire = '0;
  logic [8:0] prod_q [N][$];
  logic [7:0] exp_q  [N][$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() != 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_payload[i*W +: W] = prod_q[i][0][7:0];
        bus.req_last[i]           = prod_q[i][0][8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i]) void'(prod_q[i].pop_front());
    drive();
    #1;
  endtask

  // mode: 0 no last, 1 last on final beat, 2 last on every beat
  task automatic load(int i, int n, int mode);
    logic [7:0] p;
    logic       l;
    for (int j = 0; j < n; j++) begin
      p = 8'(i * 64 + (seq % 64));
      seq++;
      l = (mode == 2) || (mode == 1 && j == n - 1);
      prod_q[i].push_back({l, p});
      exp_q[i].push_back(p);
    end
    drive();
  endtask

  task automatic run_burst(string tag, logic [N-1:0] g, int nb);
    int b0;
    b0 = beats;
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    for (int k = 0; k < 300 && bus.grant != '0; k++) step();
    chk({tag, "_beats"}, beats - b0, nb);
    chk({tag, "_drop"}, 32'(bus.grant), 0);
  endtask

  initial begin
    int o;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      if (bus.fifo_push_valid && bus.fifo_push_ready) begin
        beats++;
        o = 0;
        for (int i = 0; i < N; i++)
          if (bus.grant[i]) o = i;
        if (exp_q[o].size() == 0)
          chk("push_extra", 1, 0);
        else
          chk("push_data", 32'(bus.fifo_push_payload),
              32'(exp_q[o].pop_front()));
      end
      if (bus.fifo_flush) flushes++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int fl0;
    reset                = 1'b1;
    bus.req_valid        = '0;
    bus.req_last         = '0;
    bus.req_payload      = '0;
    bus.fifo_push_ready  = 1'b1;
    bus.fifo_occupancy   = '0;
    bus.flush_req        = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pvalid", 32'(bus.fifo_push_valid), 0);
    chk("rst_flush", 32'(bus.fifo_flush), 0);
    chk("rst_ack", 32'(bus.flush_ack), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    step();

    // single producer, 3 beats
    load(0, 3, 1);
    step();
    run_burst("s1", 4'b0001, 3);
    // rr_ptr now 1: requester 1 wins over 0
    load(0, 1, 1);
    load(1, 1, 1);
    step();
    run_burst("s1_rr1", 4'b0010, 1);
    step();
    run_burst("s1_rr0", 4'b0001, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // all producers valid, last on every beat
    for (int i = 0; i < N; i++) load(i, 2, 2);
    step();
    for (int k = 0; k < 8; k++) begin
      run_burst("s2", 4'(1 << (k % 4)), 1);
      step();
    end

    // MAX_BURST cut, others served before regrant
    load(2, 16, 0);
    step();
    load(3, 1, 1);
    load(0, 1, 1);
    run_burst("s3_cut", 4'b0100, 8);
    step();
    run_burst("s3_p3", 4'b1000, 1);
    step();
    run_burst("s3_p0", 4'b0001, 1);
    step();
    run_burst("s3_regrant", 4'b0100, 8);

    // free-space gate
    bus.fifo_occupancy = 5'd13;
    load(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s4_hold", 32'(bus.grant), 0);
    end
    bus.fifo_occupancy = 5'd12;
    step();
    run_burst("s4_admit", 4'b0010, 1);
    bus.fifo_occupancy = '0;

    // flush deferred to burst end
    fl0 = flushes;
    load(2, 5, 1);
    step();
    chk("s5_grant", 32'(bus.grant), 32'(4'b0100));
    b0 = beats;
    step();
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    for (int k = 0; k < 300 && bus.grant != '0; k++) step();
    chk("s5_beats", beats - b0, 5);
    chk("s5_defer", 32'(bus.fifo_flush), 0);
    load(3, 1, 1);
    step();
    chk("s5_flush", 32'(bus.fifo_flush), 1);
    chk("s5_ack", 32'(bus.flush_ack), 1);
    chk("s5_pvalid", 32'(bus.fifo_push_valid), 0);
    chk("s5_ready", 32'(bus.req_ready), 0);
    chk("s5_busy", 32'(bus.busy), 1);
    step();
    chk("s5_once", flushes - fl0, 1);
    step();
    run_burst("s5_next", 4'b1000, 1);

    // reset mid-burst under backpressure
    load(0, 1, 1);
    step();
    run_burst("s6_pre", 4'b0001, 1);
    load(2, 3, 1);
    step();
    chk("s6_grant", 32'(bus.grant), 32'(4'b0100));
    bus.fifo_push_ready = 1'b0;
    step();
    chk("s6_stall", 32'(bus.grant), 32'(4'b0100));
    chk("s6_pvalid", 32'(bus.fifo_push_valid), 1);
    reset = 1'b1;
    step();
    chk("s6_rgrant", 32'(bus.grant), 0);
    chk("s6_rready", 32'(bus.req_ready), 0);
    chk("s6_rpvalid", 32'(bus.fifo_push_valid), 0);
    chk("s6_rbusy", 32'(bus.busy), 0);
    reset = 1'b0;
    load(0, 1, 1);
    bus.fifo_push_ready = 1'b1;
    step();
    run_burst("s6_rr0", 4'b0001, 1);
    step();
    run_burst("s6_resume", 4'b0100, 3);

    for (int i = 0; i < N; i++)
      chk("drain", exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_fifo_push_arbiter.md
Name: stream_fifo_push_arbiter

Overview:
- Shares the single push port of the 16-deep, 8-bit stream FIFO between NUM_REQ producer streams.
- Round-robin arbitration with burst lock: a granted producer keeps the port until it sends a `last` beat or reaches MAX_BURST beats.
- Admission is gated on FIFO free space.
- Also sequences FIFO flushes so they never cut a burst in half.

Parameters:
- NUM_REQ, 4, number of producer streams (2..8)
- DATA_W, 8, payload width
- DEPTH, 16, FIFO depth; occupancy width is log2(DEPTH)+1
- MAX_BURST, 8, maximum beats per grant (1..255)
- START_FREE, 4, minimum free FIFO entries required to start a burst (1..DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-producer valid
- req_ready  out  NUM_REQ  per-producer ready
- req_payload  in  NUM_REQ*DATA_W  packed payloads; requester i is bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  per-producer end-of-burst marker
- fifo_push_valid  out  1  to FIFO push valid
- fifo_push_ready  in  1  from FIFO push ready
- fifo_push_payload  out  DATA_W  to FIFO push payload
- fifo_occupancy  in  log2(DEPTH)+1  from FIFO occupancy
- fifo_flush  out  1  to FIFO flush (single-cycle pulse)
- flush_req  in  1  flush request, sticky until accepted
- flush_ack  out  1  one-cycle pulse in the cycle fifo_flush is driven
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- busy  out  1  high in BURST or FLUSH

Behaviour:
- Reset is synchronous on clk when reset=1.
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, flush_pend=0.
  - All outputs 0.
- States are IDLE, BURST and FLUSH.
- free = DEPTH - fifo_occupancy, computed at occupancy width with no wrap (occupancy never exceeds DEPTH).
- IDLE:
  - If flush_pend or flush_req, go to FLUSH. Flush has priority over new grants.
  - Else, if any req_valid and free >= START_FREE, pick the first valid requester scanning from rr_ptr upward with modulo wrap. Register grant as one-hot, set beat_cnt=0, go to BURST.
  - Selection takes effect next cycle: one idle cycle between bursts is required.
- BURST, owner g:
  - Pure combinational pass-through, zero latency.
  - fifo_push_valid = req_valid[g]
  - fifo_push_payload = payload of g
  - req_ready[g] = fifo_push_ready
  - All other req_ready = 0
  - beat = fifo_push_valid && fifo_push_ready. Each beat increments beat_cnt.
  - Burst ends on a beat with req_last[g]=1 or beat_cnt==MAX_BURST-1. On end: rr_ptr = (g+1) mod NUM_REQ, grant=0, go to IDLE.
  - A stalled owner (valid low) keeps the grant indefinitely; there is no timeout.
  - Free space is checked only at burst start. FIFO backpressure inside a burst is honoured via fifo_push_ready.
- flush_req seen in BURST sets flush_pend. The flush is deferred until the burst ends.
- FLUSH lasts exactly one cycle:
  - fifo_flush=1, flush_ack=1, flush_pend cleared, go to IDLE.
  - No push is granted in this cycle; all req_ready=0 and fifo_push_valid=0.
  - rr_ptr is unchanged.
- A flush_req still high in the cycle after flush_ack counts as a new request.
- fifo_push_valid must not depend on fifo_push_ready (no combinational loop).
- Reset mid-burst: the grant is dropped immediately. A partial burst may remain in the FIFO; clearing it is the caller's responsibility.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, BURST, FLUSH}
  - an occupancy-width helper function, log2(DEPTH)+1
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot pick and any_valid.
- All sequential logic lives in the top.

Test Plan:
- Single producer: req0 sends 3 beats, last on the 3rd, fifo_push_ready=1.
  - grant=0001 the cycle after request; 3 pushes with matching payloads; grant=0 on the next cycle; rr_ptr=1.
- All 4 producers continuously valid, last on every beat:
  - grant order is 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- MAX_BURST=8, req2 valid for 20 beats with no last:
  - grant drops after exactly 8 beats; req2 is regranted only after other valid requesters are served.
- fifo_occupancy=13 (free=3) with START_FREE=4 and req1 valid:
  - no grant.
  - When occupancy drops to 12, grant=0010 the next cycle.
- flush_req pulsed at beat 2 of a 5-beat burst:
  - all 5 beats complete.
  - fifo_flush and flush_ack are high for exactly one cycle immediately after the burst end.
  - no push occurs during the flush.
- reset asserted mid-burst with fifo_push_ready=0:
  - next cycle grant=0, req_ready=0, fifo_push_valid=0, busy=0.
  - after release, arbitration restarts from requester 0.
